// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO, exposed as a
// three-register device on the request/rvalid bus with a level interrupt.
module uart_rx #(
  parameter int ClockFrequency = 50_000_000,
  parameter int BaudRate       = 115_200,
  parameter int FifoDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        device_req_i,
  input  logic [31:0] device_addr_i,
  input  logic        device_we_i,
  input  logic [3:0]  device_be_i,
  input  logic [31:0] device_wdata_i,
  output logic        device_rvalid_o,
  output logic [31:0] device_rdata_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);

  localparam int ClocksPerBit = ClockFrequency / BaudRate;
  localparam int HalfBit      = ClocksPerBit / 2;
  localparam int CntW         = $clog2(ClocksPerBit);
  localparam int PtrW         = $clog2(FifoDepth);
  localparam int CountW       = PtrW + 1;

  localparam logic [CntW-1:0]   BitLast  = CntW'(ClocksPerBit - 1);
  localparam logic [CntW-1:0]   HalfLast = CntW'(HalfBit - 1);
  localparam logic [CountW-1:0] FullCnt  = CountW'(FifoDepth);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_e;

  // Register file
  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  state_e        state_q, state_d;
  logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    mem_q [FifoDepth];
  logic [7:0]    mem_d [FifoDepth];
  logic [PtrW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic          rvalid_q, rvalid_d;
  logic [31:0]   rdata_q, rdata_d;

  // Internal strobes
  logic       rx_s;
  logic       push_s, fe_set_s;
  logic       not_empty_s, full_s, pop_s, do_push_s, ovr_set_s;
  logic       rd_s, wr_s;
  logic [1:0] sel_s;
  logic       ovr_clr_s, fe_clr_s;
  logic       unused_bits_s;

  assign rx_s = sync2_q;
  assign unused_bits_s = ^{device_addr_i[31:4], device_addr_i[1:0],
                           device_be_i[3:1], device_wdata_i[31:4],
                           device_wdata_i[1]};

  // Two-flop synchroniser for the asynchronous serial pin
  always_comb begin
    sync1_d = uart_rx_i;
    sync2_d = sync1_q;
  end

  // Receive FSM: start detection, mid-bit sampling, stop check, break hold-off
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_s    = 1'b0;
    fe_set_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (clk_cnt_q == HalfLast) begin
          clk_cnt_d = '0;
          if (!rx_s) begin
            state_d   = ST_DATA;
            bit_idx_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      ST_STOP: begin
        if (clk_cnt_q == BitLast) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            push_s  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_set_s = 1'b1;
            state_d  = ST_BREAK;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CntW'(1);
        end
      end
      ST_BREAK: begin
        if (rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BREAK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bus decode and registered read-data mux (values reflect pre-update state)
  always_comb begin
    sel_s       = device_addr_i[3:2];
    rd_s        = device_req_i & ~device_we_i;
    wr_s        = device_req_i & device_we_i;
    not_empty_s = (count_q != '0);
    full_s      = (count_q == FullCnt);
    pop_s       = rd_s && (sel_s == 2'd0) && not_empty_s;
    rvalid_d    = device_req_i;
    rdata_d     = 32'd0;
    if (rd_s) begin
      case (sel_s)
        2'd0: begin
          if (not_empty_s) begin
            rdata_d = {24'd0, mem_q[rptr_q]};
          end else begin
            rdata_d = 32'd0;
          end
        end
        2'd1:    rdata_d = {28'd0, frame_err_q, overrun_q, full_s, not_empty_s};
        2'd2:    rdata_d = {31'd0, irq_en_q};
        default: rdata_d = 32'd0;
      endcase
    end else begin
      rdata_d = 32'd0;
    end
  end

  // FIFO storage and pointers; a pop frees the slot for a same-cycle push
  always_comb begin
    do_push_s = push_s && (!full_s || pop_s);
    ovr_set_s = push_s && full_s && !pop_s;
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    if (do_push_s) begin
      mem_d[wptr_q] = shift_q;
      wptr_d        = wptr_q + PtrW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PtrW'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (do_push_s && !pop_s) begin
      count_d = count_q + CountW'(1);
    end else if (pop_s && !do_push_s) begin
      count_d = count_q - CountW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Sticky status flags, interrupt enable and interrupt level; set beats clear
  always_comb begin
    ovr_clr_s = wr_s && (sel_s == 2'd1) && device_be_i[0] && device_wdata_i[2];
    fe_clr_s  = wr_s && (sel_s == 2'd1) && device_be_i[0] && device_wdata_i[3];
    if (ovr_set_s) begin
      overrun_d = 1'b1;
    end else if (ovr_clr_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
    if (fe_set_s) begin
      frame_err_d = 1'b1;
    end else if (fe_clr_s) begin
      frame_err_d = 1'b0;
    end else begin
      frame_err_d = frame_err_q;
    end
    if (wr_s && (sel_s == 2'd2) && device_be_i[0]) begin
      irq_en_d = device_wdata_i[0];
    end else begin
      irq_en_d = irq_en_q;
    end
    irq_d = irq_en_q & not_empty_s;
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      for (int i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= 8'd0;
      end
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      irq_en_q    <= 1'b0;
      irq_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
      irq_en_q    <= irq_en_d;
      irq_q       <= irq_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign device_rvalid_o = rvalid_q;
  assign device_rdata_o  = rdata_q;
  assign irq_o           = irq_q;

endmodule
